button_debounce: RTL and testbench

Per-button input conditioner between the board button pins and every consumer of `buttons` in `top`: the icicle SoC and the arduino pulse generator. Each raw input is synchronised into the `clk` domain (the PLL clock, 36 MHz) and debounced with a stability counter. The block then produces a clean level, one-cycle press/release strobes and a sticky press flag per button that software clears. Optionally it also emits a one-shot long-press strobe.

---
 rtl/button_debounce_pkg.sv | 12 +
 rtl/debounce_channel.sv | 115 +++++++++++
 rtl/button_debounce.sv | 47 ++++
 tb/tb_button_debounce.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/button_debounce_pkg.sv
// Shared types and default timing constants for the button debouncer.
package button_debounce_pkg;

    typedef enum logic {
        STABLE   = 1'b0,
        CHANGING = 1'b1
    } db_state_t;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT  = 36000;
    localparam int unsigned LONGPRESS_CYCLES_DEFAULT = 36000000;

endpackage

// File: rtl/debounce_channel.sv
// One button: polarity fix, 2-flop synchroniser, stability-counter debounce FSM,
// press/release strobes and, with BUTTON_LONGPRESS_EN defined, a one-shot hold timer.
module debounce_channel
    import button_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned LONGPRESS_CYCLES = LONGPRESS_CYCLES_DEFAULT,
    parameter logic        ACTIVE_LOW       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic pressed,
    output logic released,
    output logic long_press
);

    localparam int unsigned      CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || LONGPRESS_CYCLES < 2) begin : g_param_check
        $error("debounce_channel: DEBOUNCE_CYCLES and LONGPRESS_CYCLES must be >= 2");
    end

    logic            sync1;
    logic            sync2;
    db_state_t       state;
    logic [CW-1:0]   cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw ^ ACTIVE_LOW;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= STABLE;
            cnt      <= '0;
            level    <= 1'b0;
            pressed  <= 1'b0;
            released <= 1'b0;
        end else begin
            pressed  <= 1'b0;
            released <= 1'b0;
            case (state)
                STABLE: begin
                    if (sync2 != level) begin
                        state <= CHANGING;
                        cnt   <= CW'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                CHANGING: begin
                    if (sync2 == level) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        // Level and its strobe update on the same edge.
                        level    <= ~level;
                        pressed  <= ~level;
                        released <= level;
                        cnt      <= '0;
                        state    <= STABLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

`ifdef BUTTON_LONGPRESS_EN
    localparam int unsigned   HW        = $clog2(LONGPRESS_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONGPRESS_CYCLES - 1);

    logic [HW-1:0] hold;
    logic          fired;

    // Level low covers the release strobe cycle; 'fired' makes the strobe one-shot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold       <= '0;
            fired      <= 1'b0;
            long_press <= 1'b0;
        end else begin
            long_press <= 1'b0;
            if (!level) begin
                hold  <= '0;
                fired <= 1'b0;
            end else if (!fired) begin
                if (hold == HOLD_LAST) begin
                    long_press <= 1'b1;
                    fired      <= 1'b1;
                end else begin
                    hold <= hold + 1'b1;
                end
            end
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// Button conditioner top: one debounce_channel per button plus sticky press flags.
// Optional long-press strobe enabled by defining BUTTON_LONGPRESS_EN.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int unsigned            BUTTONCOUNT      = 4,
    parameter int unsigned            DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned            LONGPRESS_CYCLES = LONGPRESS_CYCLES_DEFAULT,
    parameter logic [BUTTONCOUNT-1:0] ACTIVE_LOW       = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BUTTONCOUNT-1:0] buttons_in,
    output logic [BUTTONCOUNT-1:0] buttons,
    output logic [BUTTONCOUNT-1:0] pressed,
    output logic [BUTTONCOUNT-1:0] released,
    output logic [BUTTONCOUNT-1:0] events,
    input  logic [BUTTONCOUNT-1:0] events_clear,
    output logic [BUTTONCOUNT-1:0] long_press
);

    for (genvar i = 0; i < BUTTONCOUNT; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONGPRESS_CYCLES (LONGPRESS_CYCLES),
            .ACTIVE_LOW       (ACTIVE_LOW[i])
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .raw        (buttons_in[i]),
            .level      (buttons[i]),
            .pressed    (pressed[i]),
            .released   (released[i]),
            .long_press (long_press[i])
        );
    end

    // A press arriving with a clear still sets the flag, so no press is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            events <= '0;
        end else begin
            events <= (events & ~events_clear) | pressed;
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce: vector table plus hand sequences for
// bounce rejection, active-low input, long-press and mid-count reset.
module tb_button_debounce;

    localparam int unsigned N  = 4;
    localparam int unsigned DB = 8;
    localparam int unsigned LP = 32;
    localparam logic [N-1:0] AL = 4'b0100;

`ifdef BUTTON_LONGPRESS_EN
    localparam logic [N-1:0] LP_BIT3 = 4'b1000;
    localparam int unsigned  LP_PULSES = 1;
`else
    localparam logic [N-1:0] LP_BIT3 = 4'b0000;
    localparam int unsigned  LP_PULSES = 0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] buttons_in;
    logic [N-1:0] buttons;
    logic [N-1:0] pressed;
    logic [N-1:0] released;
    logic [N-1:0] events;
    logic [N-1:0] events_clear;
    logic [N-1:0] long_press;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    button_debounce #(
        .BUTTONCOUNT      (N),
        .DEBOUNCE_CYCLES  (DB),
        .LONGPRESS_CYCLES (LP),
        .ACTIVE_LOW       (AL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .buttons_in   (buttons_in),
        .buttons      (buttons),
        .pressed      (pressed),
        .released     (released),
        .events       (events),
        .events_clear (events_clear),
        .long_press   (long_press)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] in;
        logic [N-1:0] clr;
        int unsigned  steps;
        logic [N-1:0] b;
        logic [N-1:0] p;
        logic [N-1:0] r;
        logic [N-1:0] e;
    } vec_t;

    vec_t vecs[15];

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Inputs are given as logical "pressed" levels; the pin level folds in ACTIVE_LOW.
    task automatic drive(input logic [N-1:0] logical);
        buttons_in = logical ^ AL;
    endtask

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned pulses;

        vecs[0]  = '{4'h0, 4'hF,  1, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[1]  = '{4'h2, 4'h0,  9, 4'h0, 4'h0, 4'h0, 4'h0};
        vecs[2]  = '{4'h2, 4'h0,  1, 4'h2, 4'h2, 4'h0, 4'h0};
        vecs[3]  = '{4'h2, 4'h0,  1, 4'h2, 4'h0, 4'h0, 4'h2};
        vecs[4]  = '{4'h0, 4'h0,  9, 4'h2, 4'h0, 4'h0, 4'h2};
        vecs[5]  = '{4'h0, 4'h0,  1, 4'h0, 4'h0, 4'h2, 4'h2};
        vecs[6]  = '{4'h0, 4'h0,  1, 4'h0, 4'h0, 4'h0, 4'h2};
        vecs[7]  = '{4'h2, 4'h0,  9, 4'h0, 4'h0, 4'h0, 4'h2};
        vecs[8]  = '{4'h2, 4'h0,  1, 4'h2, 4'h2, 4'h0, 4'h2};
        vecs[9]  = '{4'h2, 4'h2,  1, 4'h2, 4'h0, 4'h0, 4'h2};
        vecs[10] = '{4'h2, 4'h0,  3, 4'h2, 4'h0, 4'h0, 4'h2};
        vecs[11] = '{4'h2, 4'h2,  1, 4'h2, 4'h0, 4'h0, 4'h0};
        vecs[12] = '{4'h2, 4'h0,  1, 4'h2, 4'h0, 4'h0, 4'h0};
        vecs[13] = '{4'h0, 4'h0, 10, 4'h0, 4'h0, 4'h2, 4'h0};
        vecs[14] = '{4'h0, 4'h0,  1, 4'h0, 4'h0, 4'h0, 4'h0};

        reset        = 1'b1;
        events_clear = '0;
        drive(4'hF);
        step(3);
        check("rst_buttons",  buttons,    4'h0);
        check("rst_pressed",  pressed,    4'h0);
        check("rst_released", released,   4'h0);
        check("rst_events",   events,     4'h0);
        check("rst_long",     long_press, 4'h0);

        reset = 1'b0;
        step(DB + 1);
        check("post_rst_early_buttons", buttons, 4'h0);
        step(1);
        check("post_rst_buttons", buttons, 4'hF);
        check("post_rst_pressed", pressed, 4'hF);
        step(1);
        check("post_rst_pressed_gone", pressed, 4'h0);
        check("post_rst_events", events, 4'hF);

        drive(4'h0);
        step(DB + 1);
        check("rel_all_early", buttons, 4'hF);
        step(1);
        check("rel_all_buttons",  buttons,  4'h0);
        check("rel_all_released", released, 4'hF);
        check("rel_all_pressed",  pressed,  4'h0);
        step(1);
        check("rel_all_released_gone", released, 4'h0);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].in);
            events_clear = vecs[i].clr;
            step(vecs[i].steps);
            check($sformatf("vec%0d_buttons", i),  buttons,    vecs[i].b);
            check($sformatf("vec%0d_pressed", i),  pressed,    vecs[i].p);
            check($sformatf("vec%0d_released", i), released,   vecs[i].r);
            check($sformatf("vec%0d_events", i),   events,     vecs[i].e);
            check($sformatf("vec%0d_long", i),     long_press, 4'h0);
        end
        events_clear = '0;

        // Bit 0 bounces with 3-cycle runs, well short of the stability window.
        for (int i = 0; i < 40; i++) begin
            drive(((i / 3) % 2 == 0) ? 4'h1 : 4'h0);
            step(1);
            check($sformatf("bounce%0d_buttons", i), buttons, 4'h0);
            check($sformatf("bounce%0d_strobes", i), pressed | released, 4'h0);
        end
        drive(4'h1);
        step(DB + 1);
        check("bounce_settle_early", pressed, 4'h0);
        step(1);
        check("bounce_settle_pressed", pressed, 4'h1);
        check("bounce_settle_buttons", buttons, 4'h1);
        drive(4'h0);
        step(DB + 2);
        check("bounce_release", released, 4'h1);

        buttons_in = 4'b0000;
        step(DB + 1);
        check("al_early", buttons, 4'h0);
        step(1);
        check("al_buttons", buttons, 4'h4);
        check("al_pressed", pressed, 4'h4);
        buttons_in = 4'b0100;
        step(DB + 2);
        check("al_release", released, 4'h4);

        drive(4'h8);
        step(DB + 2);
        check("lp_pressed", pressed, 4'h8);
        pulses = 0;
        for (int k = 1; k <= 50; k++) begin
            step(1);
            if (long_press[3]) pulses++;
            check($sformatf("lp_hold%0d", k), long_press, (k == LP) ? LP_BIT3 : 4'h0);
        end
        drive(4'h0);
        for (int k = 1; k <= DB + 2; k++) begin
            step(1);
            if (long_press[3]) pulses++;
        end
        check("lp_release", released, 4'h8);
        n_tests++;
        if (pulses != LP_PULSES) begin
            n_fail++;
            $display("FAIL lp_pulse_count: got %0d expected %0d", pulses, LP_PULSES);
        end

        drive(4'h8);
        step(DB + 2);
        check("lp_short_pressed", pressed, 4'h8);
        for (int k = 1; k <= 20; k++) begin
            step(1);
            check($sformatf("lp_short%0d", k), long_press, 4'h0);
        end
        drive(4'h0);
        for (int k = 1; k <= 12; k++) begin
            step(1);
            check($sformatf("lp_short_rel%0d", k), long_press, 4'h0);
            if (k == DB + 2) check("lp_short_released", released, 4'h8);
        end

        drive(4'h1);
        step(7);
        reset = 1'b1;
        step(1);
        check("midrst_buttons", buttons,    4'h0);
        check("midrst_pressed", pressed,    4'h0);
        check("midrst_events",  events,     4'h0);
        check("midrst_long",    long_press, 4'h0);
        step(1);
        reset = 1'b0;
        step(DB + 1);
        check("midrst_early", pressed, 4'h0);
        step(1);
        check("midrst_pressed", pressed, 4'h1);
        check("midrst_buttons_after", buttons, 4'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
